// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - RV32I data memory with valid/ready requests and pipelined responses
module data_memory_hs #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_fun3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);
    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int LAST = READ_LAT - 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     off;
    logic [1:0]      lane;
    logic [AW-1:0]   acc_idx;
    logic            in_range;
    logic            misaligned;
    logic            bad_fun3;
    logic            fault;
    logic            accept;

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;

    logic            st_valid_q [READ_LAT];
    logic            st_valid_d [READ_LAT];
    logic            st_fault_q [READ_LAT];
    logic            st_fault_d [READ_LAT];
    logic            st_zero_q  [READ_LAT];
    logic            st_zero_d  [READ_LAT];
    logic [2:0]      st_fun3_q  [READ_LAT];
    logic [2:0]      st_fun3_d  [READ_LAT];
    logic [1:0]      st_lane_q  [READ_LAT];
    logic [1:0]      st_lane_d  [READ_LAT];
    logic [31:0]     st_word_q  [READ_LAT];
    logic [31:0]     st_word_d  [READ_LAT];

    logic [31:0]     shifted;

    // Clear sequencer: walk every word once after reset, then serve requests
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == S_CLEAR) begin
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    // FSM state and clear index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign req_ready = (state_q == S_RUN);
    assign accept    = req_valid && req_ready;

    // Address decode and fault classification; range test uses the raw address so a wrapped offset cannot alias
    always_comb begin
        off        = req_addr - BASE_ADDR;
        lane       = off[1:0];
        acc_idx    = off[AW+1:2];
        in_range   = (req_addr >= BASE_ADDR) && ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
        misaligned = 1'b0;
        case (req_fun3[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (req_we) begin
            bad_fun3 = (req_fun3 > 3'b010);
        end else begin
            bad_fun3 = (req_fun3 == 3'b011) || (req_fun3 == 3'b110) || (req_fun3 == 3'b111);
        end
        fault = !in_range || misaligned || bad_fun3;
    end

    // Write port select: clear sequencer owns the array until RUN, then good stores
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = acc_idx;
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        if (state_q == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end else if (accept && req_we && !fault) begin
            wr_en = 1'b1;
            case (req_fun3[1:0])
                2'b00: begin
                    wr_be   = 4'b0001 << lane;
                    wr_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    wr_be   = 4'b0011 << lane;
                    wr_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = req_wdata;
                end
            endcase
        end
    end

    // Storage array with byte-lane enables; contents are zeroed by the clear sequencer, not by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the raw word on acceptance; later stages only load when a valid passes so data holds
    always_comb begin
        for (int i = 0; i < READ_LAT; i++) begin
            st_valid_d[i] = 1'b0;
            st_fault_d[i] = st_fault_q[i];
            st_zero_d[i]  = st_zero_q[i];
            st_fun3_d[i]  = st_fun3_q[i];
            st_lane_d[i]  = st_lane_q[i];
            st_word_d[i]  = st_word_q[i];
        end
        st_valid_d[0] = accept;
        if (accept) begin
            st_fault_d[0] = fault;
            st_zero_d[0]  = req_we || fault;
            st_fun3_d[0]  = req_fun3;
            st_lane_d[0]  = lane;
            st_word_d[0]  = mem[acc_idx];
        end
        for (int i = 1; i < READ_LAT; i++) begin
            st_valid_d[i] = st_valid_q[i-1];
            if (st_valid_q[i-1]) begin
                st_fault_d[i] = st_fault_q[i-1];
                st_zero_d[i]  = st_zero_q[i-1];
                st_fun3_d[i]  = st_fun3_q[i-1];
                st_lane_d[i]  = st_lane_q[i-1];
                st_word_d[i]  = st_word_q[i-1];
            end
        end
    end

    // Pipeline registers; reset drops every in-flight response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                st_valid_q[i] <= 1'b0;
                st_fault_q[i] <= 1'b0;
                st_zero_q[i]  <= 1'b1;
                st_fun3_q[i]  <= 3'b000;
                st_lane_q[i]  <= 2'b00;
                st_word_q[i]  <= 32'h0;
            end
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                st_valid_q[i] <= st_valid_d[i];
                st_fault_q[i] <= st_fault_d[i];
                st_zero_q[i]  <= st_zero_d[i];
                st_fun3_q[i]  <= st_fun3_d[i];
                st_lane_q[i]  <= st_lane_d[i];
                st_word_q[i]  <= st_word_d[i];
            end
        end
    end

    // Lane extraction and sign/zero extension on the last stage's registered word
    always_comb begin
        shifted   = st_word_q[LAST] >> {st_lane_q[LAST], 3'b000};
        rsp_rdata = 32'h0;
        if (!st_zero_q[LAST]) begin
            case (st_fun3_q[LAST][1:0])
                2'b00: begin
                    if (st_fun3_q[LAST][2]) rsp_rdata = {24'h0, shifted[7:0]};
                    else                    rsp_rdata = {{24{shifted[7]}}, shifted[7:0]};
                end
                2'b01: begin
                    if (st_fun3_q[LAST][2]) rsp_rdata = {16'h0, shifted[15:0]};
                    else                    rsp_rdata = {{16{shifted[15]}}, shifted[15:0]};
                end
                default: rsp_rdata = st_word_q[LAST];
            endcase
        end
    end

    assign rsp_valid = st_valid_q[LAST];
    assign rsp_fault = st_fault_q[LAST];

endmodule
